tlb: RTL

- Fully associative instruction/data TLB that sits directly upstream of the page-table walker (ptw).
- Accepts virtual-address lookups from the core/LSU. Hits return the physical address from its entry array.
- Misses issue a walk on the ptw request/response interface, refill an entry from the returned PTE, then answer the lookup.
- Pages are 4 KiB (Sv32-style, 32-bit VA/PA).

---
 rtl/tlb_if.sv | 33 +++
 rtl/tlb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tlb_if.sv
// Core-side lookup channel and walker-side PTW channel of the TLB.
// The slave modport is the TLB; the master modport is the core/walker side.
interface tlb_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_vaddr_i;
   logic        req_store_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_paddr_o;
   logic        resp_fault_o;
   logic        resp_hit_o;
   logic        ptw_req_valid_o;
   logic        ptw_req_ready_i;
   logic [31:0] ptw_vaddr_o;
   logic        ptw_resp_valid_i;
   logic        ptw_resp_ready_o;
   logic [31:0] ptw_pte_i;

   modport slave (
      input  req_valid_i, req_vaddr_i, req_store_i, resp_ready_i,
      input  ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
      output req_ready_o, resp_valid_o, resp_paddr_o, resp_fault_o, resp_hit_o,
      output ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o
   );

   modport master (
      output req_valid_i, req_vaddr_i, req_store_i, resp_ready_i,
      output ptw_req_ready_i, ptw_resp_valid_i, ptw_pte_i,
      input  req_ready_o, resp_valid_o, resp_paddr_o, resp_fault_o, resp_hit_o,
      input  ptw_req_valid_o, ptw_vaddr_o, ptw_resp_ready_o
   );
endinterface

// File: rtl/tlb.sv
// Fully associative 4 KiB-page TLB in front of the page-table walker; one lookup in flight.
// Optional hit/miss counters are enabled by defining TLB_STATS_EN.
module tlb #(
   parameter int unsigned ENTRIES = 4,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  flush_i,
   tlb_if.slave  bus
`ifdef TLB_STATS_EN
   ,
   output logic [31:0] stat_hits_o,
   output logic [31:0] stat_misses_o
`endif
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OFF_W = 12;
   localparam int unsigned PN_W  = XLEN - OFF_W;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      PTW_REQ  = 3'd2,
      PTW_WAIT = 3'd3,
      RESP     = 3'd4
   } state_e;

   state_e            state_q;
   logic              req_ready_q;
   logic              resp_valid_q;
   logic              ptw_req_valid_q;
   logic              ptw_resp_ready_q;
   logic [XLEN-1:0]   vaddr_q;
   logic              store_q;
   logic [XLEN-1:0]   resp_paddr_q;
   logic              resp_fault_q;
   logic              resp_hit_q;

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] r_q;
   logic [ENTRIES-1:0] w_q;
   logic [ENTRIES-1:0] x_q;
   logic [PN_W-1:0]    vpn_q [ENTRIES];
   logic [PN_W-1:0]    ppn_q [ENTRIES];
   logic [IDX_W-1:0]   ptr_q;

   logic              hit_c;
   logic [IDX_W-1:0]  hit_idx_c;
   logic              hit_fault_c;
   logic              pte_fault_c;
   logic [IDX_W-1:0]  victim_c;
   logic              use_ptr_c;
   logic              unused_c;

   // Associative match of the latched VPN against all valid entries
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (vpn_q[i] == vaddr_q[XLEN-1:OFF_W])) begin
            hit_c     = 1'b1;
            hit_idx_c = IDX_W'(i);
         end
      end
   end

   // Lowest free slot wins; round-robin pointer only when the array is full
   always_comb begin
      use_ptr_c = 1'b1;
      victim_c  = ptr_q;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (use_ptr_c && !valid_q[i]) begin
            victim_c  = IDX_W'(i);
            use_ptr_c = 1'b0;
         end
      end
   end

   assign hit_fault_c = store_q ? !w_q[hit_idx_c] : !r_q[hit_idx_c];
   assign pte_fault_c = !bus.ptw_pte_i[0] | (store_q ? !bus.ptw_pte_i[2] : !bus.ptw_pte_i[1]);

   // X is kept in the entry for completeness; PTE bits [11:4] carry nothing we use
   assign unused_c = ^{bus.ptw_pte_i[11:4], x_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         ptw_req_valid_q  <= 1'b0;
         ptw_resp_ready_q <= 1'b0;
         vaddr_q          <= '0;
         store_q          <= 1'b0;
         resp_paddr_q     <= '0;
         resp_fault_q     <= 1'b0;
         resp_hit_q       <= 1'b0;
         valid_q          <= '0;
         r_q              <= '0;
         w_q              <= '0;
         x_q              <= '0;
         ptr_q            <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            vpn_q[i] <= '0;
            ppn_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid_i) begin
                  vaddr_q     <= bus.req_vaddr_i;
                  store_q     <= bus.req_store_i;
                  req_ready_q <= 1'b0;
                  state_q     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit_c) begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= 1'b1;
                  resp_fault_q <= hit_fault_c;
                  resp_paddr_q <= hit_fault_c ? '0 : {ppn_q[hit_idx_c], vaddr_q[OFF_W-1:0]};
                  state_q      <= RESP;
               end else begin
                  ptw_req_valid_q <= 1'b1;
                  state_q         <= PTW_REQ;
               end
            end
            PTW_REQ: begin
               if (bus.ptw_req_ready_i) begin
                  ptw_req_valid_q  <= 1'b0;
                  ptw_resp_ready_q <= 1'b1;
                  state_q          <= PTW_WAIT;
               end
            end
            PTW_WAIT: begin
               if (bus.ptw_resp_valid_i) begin
                  ptw_resp_ready_q <= 1'b0;
                  resp_valid_q     <= 1'b1;
                  resp_hit_q       <= 1'b0;
                  resp_fault_q     <= pte_fault_c;
                  resp_paddr_q     <= pte_fault_c ? '0
                                      : {bus.ptw_pte_i[XLEN-1:OFF_W], vaddr_q[OFF_W-1:0]};
                  state_q          <= RESP;
                  if (bus.ptw_pte_i[0]) begin
                     valid_q[victim_c] <= 1'b1;
                     vpn_q[victim_c]   <= vaddr_q[XLEN-1:OFF_W];
                     ppn_q[victim_c]   <= bus.ptw_pte_i[XLEN-1:OFF_W];
                     r_q[victim_c]     <= bus.ptw_pte_i[1];
                     w_q[victim_c]     <= bus.ptw_pte_i[2];
                     x_q[victim_c]     <= bus.ptw_pte_i[3];
                     if (use_ptr_c) ptr_q <= ptr_q + IDX_W'(1);
                  end
               end
            end
            RESP: begin
               if (bus.resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Flush overrides any refill landing on the same edge
         if (flush_i) valid_q <= '0;
      end
   end

   assign bus.req_ready_o      = req_ready_q;
   assign bus.resp_valid_o     = resp_valid_q;
   assign bus.resp_paddr_o     = resp_paddr_q;
   assign bus.resp_fault_o     = resp_fault_q;
   assign bus.resp_hit_o       = resp_hit_q;
   assign bus.ptw_req_valid_o  = ptw_req_valid_q;
   assign bus.ptw_vaddr_o      = vaddr_q;
   assign bus.ptw_resp_ready_o = ptw_resp_ready_q;

`ifdef TLB_STATS_EN
   logic [31:0] hits_q;
   logic [31:0] misses_q;

   // Saturating hit/miss counters, untouched by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if ((state_q == RESP) && bus.resp_ready_i) begin
         if (resp_hit_q) begin
            if (hits_q != '1) hits_q <= hits_q + 32'd1;
         end else begin
            if (misses_q != '1) misses_q <= misses_q + 32'd1;
         end
      end
   end

   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;
`endif

endmodule
